// File: rtl/clk_en_pkg.sv
// Shared types and constants for the clock-enable controller.
//   state_t           controller states
//   DEFAULT_DIV_BOARD tick period used on the board (clk cycles)
//   SIM_DIV           short period handy for simulation builds
//   onehot()          index -> one-hot vector (caller narrows to its width)
package clk_en_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SHOT = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DIV_BOARD = 100000;
    localparam int unsigned SIM_DIV           = 4;

    function automatic logic [31:0] onehot(input logic [31:0] idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/clk_en_div_core.sv
// Period counter with terminal-count compare and registered tick.
//   clk, reset  system clock, synchronous active-high reset
//   enable      count while high
//   clear       force count and tick to zero (wins over enable)
//   div         period in clk cycles, never zero
//   wrap        terminal count reached this cycle (tick issued at this edge)
//   clk_en      registered one-cycle tick
module clk_en_div_core #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] div,
    output logic             wrap,
    output logic             clk_en
);

    logic [CNT_W-1:0] count;

    assign wrap = enable && !clear && (count == div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            clk_en <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            clk_en <= 1'b0;
        end else if (wrap) begin
            count  <= '0;
            clk_en <= 1'b1;
        end else if (enable) begin
            count  <= count + CNT_W'(1);
            clk_en <= 1'b0;
        end else begin
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_en_ctrl.sv
// Programmable clock-enable controller: periodic or one-shot ticks,
// round-robined across NSLOT consumers.
//   clk, reset        system clock, synchronous active-high reset
//   cfg_valid/cfg_div period load request (0 means 1); cfg_ready accepts it
//   start, oneshot    begin ticking from IDLE; oneshot selects single pulse
//   stop              halt ticking, back to IDLE
//   busy              RUN or SHOT
//   clk_en            one-cycle tick
//   slot, slot_en     consumer served by the current/next tick, one-hot steer
//
// state | meaning
// IDLE  | no ticks; period loads go straight to div_reg
// RUN   | periodic ticks every div_reg cycles; loads wait in pend until a wrap
// SHOT  | one tick after div_reg cycles, then IDLE
module clk_en_ctrl
    import clk_en_pkg::*;
#(
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_BOARD,
    parameter int unsigned NSLOT       = 4,
    parameter int unsigned SLOT_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    input  logic              start,
    input  logic              oneshot,
    input  logic              stop,
    output logic              busy,
    output logic              clk_en,
    output logic [SLOT_W-1:0] slot,
    output logic [NSLOT-1:0]  slot_en
);

    state_t           state;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] pend;
    logic             pend_vld;
    logic             xfer;
    logic             wrap;
    logic             enable;
    logic             clear;
    logic             to_idle;
    logic [NSLOT-1:0] slot_oh;

    function automatic logic [CNT_W-1:0] nonzero(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign cfg_ready = !pend_vld;
    assign xfer      = cfg_valid && cfg_ready;
    assign enable    = (state != IDLE);
    // Start and stop both restart the count; stop beats start in IDLE.
    assign clear     = (state == IDLE) ? (start && !stop) : stop;
    assign to_idle   = stop || ((state == SHOT) && wrap);

    clk_en_div_core #(.CNT_W(CNT_W)) u_div_core (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .div    (div_reg),
        .wrap   (wrap),
        .clk_en (clk_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            div_reg  <= CNT_W'(DEFAULT_DIV);
            pend     <= '0;
            pend_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) div_reg <= nonzero(cfg_div);
                    if (start && !stop) begin
                        state <= oneshot ? SHOT : RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN, SHOT: begin
                    if (to_idle) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        // A load arriving on the exit edge is the newest value.
                        if (xfer)          div_reg <= nonzero(cfg_div);
                        else if (pend_vld) div_reg <= pend;
                        pend_vld <= 1'b0;
                    end else begin
                        if (wrap && pend_vld) begin
                            div_reg  <= pend;
                            pend_vld <= 1'b0;
                        end
                        // xfer implies !pend_vld, so this never collides with the load above.
                        if (xfer) begin
                            pend     <= nonzero(cfg_div);
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            slot <= '0;
        else if (clk_en)
            slot <= (slot == SLOT_W'(NSLOT - 1)) ? '0 : slot + SLOT_W'(1);
    end

    assign slot_oh = NSLOT'(onehot(32'(slot)));
    assign slot_en = clk_en ? slot_oh : '0;

endmodule

// File: tb/tb_clk_en_ctrl.sv
module tb_clk_en_ctrl;

    localparam int unsigned CNT_W  = 17;
    localparam int unsigned DEF    = 7;
    localparam int unsigned NSLOT  = 4;
    localparam int unsigned SLOT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             start = 1'b0;
    logic             oneshot = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             clk_en;
    logic [SLOT_W-1:0] slot;
    logic [NSLOT-1:0] slot_en;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: ticks are scheduled as absolute edge numbers.
    int m_t      = 0;
    int m_next   = 0;
    int m_period = DEF;
    int m_pend   = 0;
    bit m_pv     = 0;
    bit m_run    = 0;
    bit m_shot   = 0;
    bit m_pulse  = 0;
    int m_slot   = 0;

    always #5 clk = ~clk;

    clk_en_ctrl #(
        .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .NSLOT(NSLOT), .SLOT_W(SLOT_W)
    ) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .start(start), .oneshot(oneshot), .stop(stop),
        .busy(busy), .clk_en(clk_en), .slot(slot), .slot_en(slot_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, m_t, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input bit cv, input int cd,
                              input bit st, input bit os, input bit sp);
        bit adv;
        bit xf;
        bit pulse;
        int fixd;
        m_t++;
        adv = m_pulse;
        if (rs) begin
            m_run = 0; m_period = DEF; m_pv = 0; m_slot = 0; m_pulse = 0;
        end else begin
            xf    = cv && !m_pv;
            fixd  = (cd == 0) ? 1 : cd;
            pulse = 0;
            if (!m_run) begin
                if (xf) m_period = fixd;
                if (st && !sp) begin
                    m_run = 1; m_shot = os; m_next = m_t + m_period;
                end
            end else if (sp) begin
                m_run = 0;
                if (xf) m_period = fixd;
                else if (m_pv) m_period = m_pend;
                m_pv = 0;
            end else if (m_t == m_next) begin
                pulse = 1;
                if (m_pv) begin m_period = m_pend; m_pv = 0; end
                if (m_shot) begin
                    m_run = 0;
                    if (xf) m_period = fixd;
                end else begin
                    m_next = m_t + m_period;
                    if (xf) begin m_pend = fixd; m_pv = 1; end
                end
            end else if (xf) begin
                m_pend = fixd; m_pv = 1;
            end
            if (adv) m_slot = (m_slot + 1) % NSLOT;
            m_pulse = pulse;
        end
    endtask

    task automatic step(input bit rs, input bit cv, input int cd,
                        input bit st, input bit os, input bit sp);
        logic [NSLOT-1:0] exp_en;
        reset = rs; cfg_valid = cv; cfg_div = CNT_W'(cd);
        start = st; oneshot = os; stop = sp;
        @(posedge clk);
        model_edge(rs, cv, cd, st, os, sp);
        #1;
        exp_en = m_pulse ? NSLOT'(1 << m_slot) : '0;
        chk("clk_en",    32'(clk_en),    32'(m_pulse));
        chk("busy",      32'(busy),      32'(m_run));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
        chk("slot",      32'(slot),      32'(m_slot));
        chk("slot_en",   32'(slot_en),   32'(exp_en));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset, then default period straight out of reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(16);
        step(0, 0, 0, 0, 0, 1);

        // 1: cfg 4 in IDLE, periodic run
        step(0, 1, 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(14);
        step(0, 0, 0, 0, 0, 1);

        // 2: mid-period reconfigure, second request blocked while pending
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 1, 6, 0, 0, 0);
        step(0, 1, 9, 0, 0, 0);
        step(0, 1, 9, 0, 0, 0);
        idle(20);
        step(0, 0, 0, 0, 0, 1);

        // 3: one-shot with period 5
        step(0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(25);

        // 4: start+stop together, stop at count 2, restart
        step(0, 1, 4, 1, 0, 1);
        idle(3);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 1, 0, 0);
        idle(10);
        step(0, 0, 0, 0, 0, 1);

        // 5: zero period means a tick every cycle
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(10);
        step(0, 0, 0, 0, 0, 1);

        // 6: reset mid-run with a load pending
        step(0, 1, 4, 1, 0, 0);
        idle(2);
        step(0, 1, 8, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(9);
        step(0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 9)),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
